// File: rtl/addr4u_mon_pkg.sv
// addr4u_mon_pkg: shared widths, FSM state type and golden adder model for the fault monitor
package addr4u_mon_pkg;
  localparam int OPW = 4;
  localparam int SUMW = 5;
  typedef enum logic {MON = 1'b0, ALARM = 1'b1} mon_state_t;
  function automatic logic [SUMW-1:0] golden_sum(input logic [OPW-1:0] a, input logic [OPW-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction
endpackage

// File: rtl/addr4u_fault_monitor_if.sv
// addr4u_fault_monitor_if: sample input and result output handshakes of the fault monitor
interface addr4u_fault_monitor_if;
  import addr4u_mon_pkg::*;
  logic            in_valid;
  logic            in_ready;
  logic [OPW-1:0]  a;
  logic [OPW-1:0]  b;
  logic [SUMW-1:0] dut_sum;
  logic            out_valid;
  logic            out_ready;
  logic [SUMW-1:0] out_sum;
  logic            out_err;
  modport master (output in_valid, a, b, dut_sum, out_ready, input in_ready, out_valid, out_sum, out_err);
  modport slave (input in_valid, a, b, dut_sum, out_ready, output in_ready, out_valid, out_sum, out_err);
endinterface

// File: rtl/addr4u_mon_window.sv
// addr4u_mon_window: per-window mismatch counting and sticky alarm FSM
module addr4u_mon_window
  import addr4u_mon_pkg::*;
#(
  parameter int WIN = 16,
  parameter int THRESH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic acc,
  input  logic mism,
  input  logic clr,
  output logic alarm
);
  localparam int CW = $clog2(WIN + 1);
  logic [CW-1:0] r_win_cnt;
  logic [CW-1:0] r_win_err;
  mon_state_t    r_state;
  logic [CW-1:0] w_err_nxt;
  logic          w_close;
  assign w_err_nxt = r_win_err + CW'(mism);
  assign w_close = r_win_cnt == CW'(WIN - 1);
  // Count accepted samples; the closing sample is included in the evaluation and both counters restart
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win_cnt <= '0;
      r_win_err <= '0;
      r_state   <= MON;
      alarm     <= 1'b0;
    end else if (clr) begin
      r_win_cnt <= '0;
      r_win_err <= '0;
      r_state   <= MON;
      alarm     <= 1'b0;
    end else if (acc) begin
      if (w_close) begin
        r_win_cnt <= '0;
        r_win_err <= '0;
        if (r_state == MON && w_err_nxt >= CW'(THRESH)) begin
          r_state <= ALARM;
          alarm   <= 1'b1;
        end
      end else begin
        r_win_cnt <= r_win_cnt + CW'(1);
        r_win_err <= w_err_nxt;
      end
    end
  end
endmodule

// File: rtl/addr4u_fault_monitor.sv
// addr4u_fault_monitor: checks a 4-bit adder result against a golden sum and tracks faults.
// Build option ADDR4U_MON_CORRECT_EN replaces a mismatching sum with the golden one.
module addr4u_fault_monitor
  import addr4u_mon_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int WIN = 16,
  parameter int THRESH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  addr4u_fault_monitor_if.slave bus,
  output logic [CNT_W-1:0]     err_cnt,
  output logic                 alarm
);
  logic            r_out_valid;
  logic [SUMW-1:0] r_out_sum;
  logic            r_out_err;
  logic [SUMW-1:0] w_golden;
  logic [SUMW-1:0] w_sum;
  logic            w_mism;
  logic            w_acc;
  assign w_golden = golden_sum(bus.a, bus.b);
  assign w_mism = bus.dut_sum != w_golden;
  assign bus.in_ready = !r_out_valid || bus.out_ready;
  assign w_acc = bus.in_valid && bus.in_ready;
`ifdef ADDR4U_MON_CORRECT_EN
  assign w_sum = w_mism ? w_golden : bus.dut_sum;
`else
  assign w_sum = bus.dut_sum;
`endif
  assign bus.out_valid = r_out_valid;
  assign bus.out_sum = r_out_sum;
  assign bus.out_err = r_out_err;
  // Single-entry output register: load on accept, drain when taken, hold under stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_err   <= 1'b0;
    end else if (w_acc) begin
      r_out_valid <= 1'b1;
      r_out_sum   <= w_sum;
      r_out_err   <= w_mism;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end
  // Lifetime mismatch count, saturating at all-ones; clr wins over counting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt <= '0;
    else if (clr) err_cnt <= '0;
    else if (w_acc && w_mism && !(&err_cnt)) err_cnt <= err_cnt + CNT_W'(1);
  end
  addr4u_mon_window #(.WIN(WIN), .THRESH(THRESH)) u_window (
    .clk  (clk),
    .rst_n(rst_n),
    .acc  (w_acc),
    .mism (w_mism),
    .clr  (clr),
    .alarm(alarm)
  );
endmodule

// File: doc/addr4u_fault_monitor.md
Name: addr4u_fault_monitor

Overview:
Sequential checker placed directly downstream of the 4-bit unsigned adder cells (addr4u_*). It samples operand pairs and the adder's 5-bit result, recomputes a golden sum, and registers the result with a per-sample error flag. It also keeps a saturating mismatch count and raises a windowed alarm for fault-campaign benches and resilient datapaths.

Parameters:
CNT_W, 8, width of the lifetime mismatch counter (saturating)
WIN, 16, samples per observation window (>=1)
THRESH, 4, window mismatches that trigger the alarm (1..WIN)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  a, b and dut_sum are valid
in_ready  output  1  stage can accept a sample
a  input  4  operand A[3:0], driven to the adder
b  input  4  operand B[3:0], driven to the adder
dut_sum  input  5  adder output O[4:0] for the current a, b
out_valid  output  1  out_sum and out_err are valid
out_ready  input  1  downstream accepts the output
out_sum  output  5  registered sum
out_err  output  1  registered mismatch flag for this sample
err_cnt  output  CNT_W  lifetime mismatch count
alarm  output  1  sticky window alarm
clr  input  1  synchronous clear of err_cnt, window state and alarm

Behaviour:
- Reset is asynchronous and active-low; clk is the only clock.
- Reset values: out_valid=0, out_sum=0, out_err=0, err_cnt=0, alarm=0, window counters=0, FSM=MON.
- Accept: acc = in_valid & in_ready.
- in_ready = !out_valid | out_ready. This gives full throughput, and a stall holds the output register.
- Golden sum: {1'b0,a} + {1'b0,b}, 5-bit, no truncation. mism = (dut_sum != golden).
- On acc, out_sum <= dut_sum, out_err <= mism, out_valid <= 1. Latency is 1 cycle.
- out_valid clears when out_ready=1 and there is no acc. Output data stays stable while out_valid & !out_ready.
- err_cnt increments on acc & mism and saturates at 2^CNT_W-1 (no wrap).
- Window: win_cnt counts accepted samples 0..WIN-1, and win_err counts mismatches in the window.
  - On the sample that makes win_cnt reach WIN, the window evaluates win_err including the current sample.
  - After evaluation, both counters reset to 0 in the same cycle.
- FSM states:
  - MON: when a window closes with win_err >= THRESH, go to ALARM (alarm=1, registered, visible the cycle after the closing sample). Otherwise stay in MON.
  - ALARM: sticky. Counting of err_cnt and windows continues. Exit only via clr or reset.
- clr (synchronous, highest priority over acc updates):
  - err_cnt=0, win_cnt=0, win_err=0, alarm=0, FSM=MON.
  - Does not touch the out_* pipeline; a sample accepted in the clr cycle is passed through but not counted.
- in_valid while !in_ready: the sample is not taken and nothing is counted.
- Reset asserted mid-transfer: the in-flight output is discarded (out_valid=0).

Optional Feature:
Macro ADDR4U_MON_CORRECT_EN.
- With it defined, on mismatch out_sum <= golden (forward error correction); out_err still reports the mismatch.
- Without it, out_sum always equals the sampled dut_sum.
- Counters and alarm are identical in both builds.

Decomposition:
- Shared package addr4u_mon_pkg holds:
  - the 2-state FSM enum (MON, ALARM)
  - localparams OPW=4 and SUMW=5
  - a function golden_sum(a,b)
- One natural sub-module: addr4u_mon_window (win_cnt/win_err counters plus FSM, taking acc, mism and clr, producing alarm). The output register and err_cnt stay in the top.

Test Plan:
- Reset mid-stream: assert rst_n=0 while out_valid=1 -> out_valid=0, err_cnt=0 and alarm=0 immediately (asynchronous).
- Clean traffic: a=4'hF, b=4'hF, dut_sum=5'h1E, out_ready=1 -> out_sum=5'h1E and out_err=0 one cycle later. Sweep all 256 pairs -> err_cnt=0.
- Single fault: a=3, b=5, dut_sum=9 -> out_err=1, err_cnt=1. With ADDR4U_MON_CORRECT_EN, out_sum=8; without it, out_sum=9.
- Backpressure: out_ready=0 with two valid samples offered -> the first is held stable, in_ready=0, the second is not counted. With out_ready=1 the next cycle, the second is accepted.
- Alarm: defaults, 4 mismatches in samples 1..16 -> alarm=1 the cycle after sample 16. With only 3 mismatches -> alarm stays 0 and the window restarts. A clr pulse -> alarm=0, err_cnt=0.
- Saturation: CNT_W=2 with 5 faulty samples -> err_cnt stops at 3.
